// File: rtl/timer_unit_presc_mch.sv
// ============================================================================
// Module   : timer_unit_presc_mch
// Brief    : Multi-channel prescaler bank; each channel counts to its compare
//            value and emits a 1-cycle tick, optionally one-shot.
//            Optional feature macro: TIMER_PRESC_CASCADE_EN (channel chaining).
// Revision : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module timer_unit_presc_mch #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       enable_i,
    input  logic [NUM_CH-1:0]       reset_count_i,
    input  logic [NUM_CH-1:0]       write_i,
    input  logic [NUM_CH*CNT_W-1:0] write_value_i,
    input  logic [NUM_CH*CNT_W-1:0] compare_i,
    input  logic [NUM_CH-1:0]       oneshot_i,
    input  logic [NUM_CH-1:0]       cascade_i,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       done_o
);

    // Per-channel step qualifier: 1 normally, predecessor tick when chained.
    logic [NUM_CH-1:0] step;

`ifdef TIMER_PRESC_CASCADE_EN
    logic unused_cascade_bit0;
    assign unused_cascade_bit0 = cascade_i[0];
    assign step[0]             = 1'b1;

    for (genvar i = 1; i < NUM_CH; i++) begin : g_cascade
        assign step[i] = cascade_i[i] ? tick_o[i-1] : 1'b1;
    end
`else
    logic unused_cascade;
    assign unused_cascade = ^cascade_i;
    assign step           = '1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] count_q, count_d;
        logic             tick_q, tick_d;
        logic             done_q, done_d;
        logic [CNT_W-1:0] wr_val;
        logic [CNT_W-1:0] cmp_val;
        logic             run;
        logic             inc_en;

        assign wr_val  = write_value_i[i*CNT_W +: CNT_W];
        assign cmp_val = compare_i[i*CNT_W +: CNT_W];
        assign run     = enable_i[i] & ~done_q;
        assign inc_en  = run & step[i];

        always_comb begin
            count_d = count_q;
            tick_d  = 1'b0;
            done_d  = done_q;

            // A pending tick wins over write so the period restarts cleanly.
            if (reset_count_i[i]) begin
                count_d = '0;
            end else if (tick_q) begin
                count_d = '0;
            end else if (write_i[i]) begin
                count_d = wr_val;
            end else if (inc_en) begin
                count_d = count_q + CNT_W'(1);
            end

            tick_d = run & (count_d >= cmp_val);

            if (oneshot_i[i] && tick_d) begin
                done_d = 1'b1;
            end else if (reset_count_i[i] || write_i[i]) begin
                done_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                count_q <= '0;
                tick_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                tick_q  <= tick_d;
                done_q  <= done_d;
            end
        end

        assign count_o[i*CNT_W +: CNT_W] = count_q;
        assign tick_o[i]                 = tick_q;
        assign done_o[i]                 = done_q;
    end

endmodule

`default_nettype wire
